// File: rtl/path_delay_meter.sv
// Measures clock edges from a stimulus-vector change to the next change of a
// synchronised DUT response; reports each result over valid/ready and tracks the maximum.
module path_delay_meter #(
  parameter int VEC_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VEC_W-1:0] stim,
  input  logic             resp,
  input  logic             clr,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic             meas_timeout,
  output logic             meas_restart,
  output logic [CNT_W-1:0] max_delay,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t             state_reg;
  state_t             state_next;
  logic [VEC_W-1:0]   stim_q;
  logic               resp_m;
  logic               resp_s;
  logic               ref_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   delay_reg;
  logic               timeout_reg;
  logic               restart_reg;
  logic [CNT_W-1:0]   max_reg;
  logic               overrun_reg;

  logic chg;
  logic resp_chg;
  logic timeout_hit;

  assign chg         = (stim != stim_q);
  assign resp_chg    = (resp_s != ref_reg);
  assign timeout_hit = (cnt_reg == TIMEOUT_CNT);

  // Edge detector and synchroniser preload the live inputs during reset so
  // release never produces a spurious change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q <= stim;
      resp_m <= resp;
      resp_s <= resp;
    end else begin
      stim_q <= stim;
      resp_m <= resp;
      resp_s <= resp_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (chg) state_next = MEASURE;
      end
      MEASURE: begin
        if (!chg && (resp_chg || timeout_hit)) state_next = REPORT;
      end
      REPORT: begin
        if (meas_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    meas_valid = (state_reg == REPORT);
    busy       = (state_reg != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_reg     <= 1'b0;
      cnt_reg     <= '0;
      delay_reg   <= '0;
      timeout_reg <= 1'b0;
      restart_reg <= 1'b0;
      max_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (chg) begin
            cnt_reg     <= CNT_ONE;
            ref_reg     <= resp_s;
            restart_reg <= 1'b0;
          end
        end
        MEASURE: begin
          if (chg) begin
            cnt_reg     <= CNT_ONE;
            ref_reg     <= resp_s;
            restart_reg <= 1'b1;
          end else if (resp_chg) begin
            delay_reg   <= cnt_reg;
            timeout_reg <= 1'b0;
            if (cnt_reg > max_reg) max_reg <= cnt_reg;
          end else if (timeout_hit) begin
            delay_reg   <= TIMEOUT_CNT;
            timeout_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        REPORT: begin
          if (chg) overrun_reg <= 1'b1;
        end
        default: ;
      endcase
      // Clear wins over a same-edge maximum update or overrun set.
      if (clr) begin
        max_reg     <= '0;
        overrun_reg <= 1'b0;
      end
    end
  end

  assign meas_delay   = delay_reg;
  assign meas_timeout = timeout_reg;
  assign meas_restart = restart_reg;
  assign max_delay    = max_reg;
  assign overrun      = overrun_reg;

endmodule
